// File: rtl/core_seq_pkg.sv
// Shared types and constants for the multi-cycle sequencing controller:
// state encoding, opcode values, halt causes and the opcode classifier.
package core_seq_pkg;

   localparam int TIMER_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_EXEC,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_WB,
      S_HALT
   } state_e;

   // Coarse instruction classes: only what the sequencer needs to steer
   // the memory phase and the write-back enables.
   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_BRANCH,
      CLS_LOAD,
      CLS_STORE,
      CLS_SYSTEM,
      CLS_ILLEGAL
   } op_class_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [1:0] ERR_EBREAK  = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   function automatic op_class_e classify(input logic [6:0] op);
      op_class_e cls;
      case (op)
         OP_LOAD:   cls = CLS_LOAD;
         OP_STORE:  cls = CLS_STORE;
         OP_SYSTEM: cls = CLS_SYSTEM;
         OP_BRANCH: cls = CLS_BRANCH;
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP:
                    cls = CLS_ALU;
         default:   cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/core_seq_wait_timer.sv
// Saturating wait-state counter; expired_o is high on the TIMEOUT-th
// consecutive enabled cycle since the last clear.
module wait_timer
   import core_seq_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/core_seq.sv
// Per-instruction sequencing FSM for the RV32 core: drives the fetch and
// load/store handshakes and the commit write-enables, all from registers.
module core_seq
   import core_seq_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   input  logic        ifu_resp_valid,
   output logic        ifu_resp_ready,
   input  logic [6:0]  opcode,
   output logic        lsu_req_valid,
   output logic        lsu_req_wen,
   input  logic        lsu_req_ready,
   input  logic        lsu_resp_valid,
   output logic        lsu_resp_ready,
   output logic        inst_we,
   output logic        rf_we,
   output logic        wb_sel,
   output logic        pc_we,
   output logic        halted,
   output logic [1:0]  err,
   output logic [31:0] instret
);

   state_e    state_q, state_d;
   op_class_e cls_q, cls_d, cls_now;
   logic [1:0] err_q, err_d;
   logic [31:0] instret_q;

   logic ifu_req_valid_q, ifu_resp_ready_q, inst_we_q;
   logic lsu_req_valid_q, lsu_req_wen_q, lsu_resp_ready_q;
   logic rf_we_q, wb_sel_q, pc_we_q, halted_q;

   logic in_wait, timer_clear, timer_expired;

   assign cls_now = classify(opcode);
   assign cls_d   = (state_q == S_EXEC) ? cls_now : cls_q;

   assign in_wait = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                    (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);
   assign timer_clear = !in_wait || (state_d != state_q);

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (timer_clear),
      .enable_i  (in_wait),
      .expired_o (timer_expired)
   );

   // Next-state decode; a handshake is tested before the timer so that it
   // wins when both land on the same cycle.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH_REQ;
         S_FETCH_REQ: begin
            if (ifu_req_ready) begin
               state_d = S_FETCH_WAIT;
            end else if (timer_expired) begin
               state_d = S_HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_FETCH_WAIT: begin
            if (ifu_resp_valid) begin
               state_d = S_EXEC;
            end else if (timer_expired) begin
               state_d = S_HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_EXEC: begin
            case (cls_now)
               CLS_LOAD, CLS_STORE: state_d = S_MEM_REQ;
               CLS_SYSTEM: begin
                  state_d = S_HALT;
                  err_d   = ERR_EBREAK;
               end
               CLS_ILLEGAL: begin
                  state_d = S_HALT;
                  err_d   = ERR_ILLEGAL;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM_REQ: begin
            if (lsu_req_ready) begin
               state_d = S_MEM_WAIT;
            end else if (timer_expired) begin
               state_d = S_HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_MEM_WAIT: begin
            if (lsu_resp_valid) begin
               state_d = S_WB;
            end else if (timer_expired) begin
               state_d = S_HALT;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_WB:    state_d = S_FETCH_REQ;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so every output is a pure
   // function of the state register and never of a bus input directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= S_IDLE;
         cls_q            <= CLS_ALU;
         err_q            <= ERR_EBREAK;
         instret_q        <= '0;
         ifu_req_valid_q  <= 1'b0;
         ifu_resp_ready_q <= 1'b0;
         inst_we_q        <= 1'b0;
         lsu_req_valid_q  <= 1'b0;
         lsu_req_wen_q    <= 1'b0;
         lsu_resp_ready_q <= 1'b0;
         rf_we_q          <= 1'b0;
         wb_sel_q         <= 1'b0;
         pc_we_q          <= 1'b0;
         halted_q         <= 1'b0;
      end else begin
         state_q          <= state_d;
         cls_q            <= cls_d;
         err_q            <= err_d;
         ifu_req_valid_q  <= (state_d == S_FETCH_REQ);
         ifu_resp_ready_q <= (state_d == S_FETCH_WAIT);
         inst_we_q        <= (state_d == S_EXEC);
         lsu_req_valid_q  <= (state_d == S_MEM_REQ);
         lsu_req_wen_q    <= (state_d == S_MEM_REQ) && (cls_d == CLS_STORE);
         lsu_resp_ready_q <= (state_d == S_MEM_WAIT);
         rf_we_q          <= (state_d == S_WB) &&
                             (cls_d != CLS_STORE) && (cls_d != CLS_BRANCH);
         wb_sel_q         <= (state_d == S_WB) && (cls_d == CLS_LOAD);
         pc_we_q          <= (state_d == S_WB);
         halted_q         <= (state_d == S_HALT);
         if (state_d == S_WB) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   assign ifu_req_valid  = ifu_req_valid_q;
   assign ifu_resp_ready = ifu_resp_ready_q;
   assign inst_we        = inst_we_q;
   assign lsu_req_valid  = lsu_req_valid_q;
   assign lsu_req_wen    = lsu_req_wen_q;
   assign lsu_resp_ready = lsu_resp_ready_q;
   assign rf_we          = rf_we_q;
   assign wb_sel         = wb_sel_q;
   assign pc_we          = pc_we_q;
   assign halted         = halted_q;
   assign err            = err_q;
   assign instret        = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: directed table of instructions and bus delays, a
// randomized instruction stream, and an asynchronous reset in MEM_WAIT.
module tb_core_seq;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [6:0]  opcode;
   logic        lsu_req_valid, lsu_req_wen, lsu_req_ready;
   logic        lsu_resp_valid, lsu_resp_ready;
   logic        inst_we, rf_we, wb_sel, pc_we, halted;
   logic [1:0]  err;
   logic [31:0] instret;

   core_seq #(
      .TIMEOUT (T)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_ready (ifu_resp_ready),
      .opcode         (opcode),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_wen    (lsu_req_wen),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_ready (lsu_resp_ready),
      .inst_we        (inst_we),
      .rf_we          (rf_we),
      .wb_sel         (wb_sel),
      .pc_we          (pc_we),
      .halted         (halted),
      .err            (err),
      .instret        (instret)
   );

   always #5 clk = ~clk;

   // Output vector bit positions, in the order returned by dutOut().
   localparam logic [9:0] O_IFREQ  = 10'b1000000000;
   localparam logic [9:0] O_IFRSP  = 10'b0100000000;
   localparam logic [9:0] O_INSTWE = 10'b0010000000;
   localparam logic [9:0] O_LREQ   = 10'b0001000000;
   localparam logic [9:0] O_WEN    = 10'b0000100000;
   localparam logic [9:0] O_LRSP   = 10'b0000010000;
   localparam logic [9:0] O_RFWE   = 10'b0000001000;
   localparam logic [9:0] O_WBSEL  = 10'b0000000100;
   localparam logic [9:0] O_PCWE   = 10'b0000000010;
   localparam logic [9:0] O_HALT   = 10'b0000000001;

   typedef struct {
      logic        irr, irv, lrr, lrv;
      logic [6:0]  op;
      logic [9:0]  o;
      logic [1:0]  e;
      logic [31:0] ir;
   } cyc_t;

   typedef struct {
      logic [6:0] op;
      int         fa, fb, ma, mb;
      int         expLen;
      logic       expHalt;
      logic [1:0] expErr;
   } vec_t;

   cyc_t        trace[$];
   vec_t        tbl[15];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] instretM = 32'd0;

   function automatic logic [9:0] dutOut();
      return {ifu_req_valid, ifu_resp_ready, inst_we, lsu_req_valid, lsu_req_wen,
              lsu_resp_ready, rf_we, wb_sel, pc_we, halted};
   endfunction

   task checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One expected cycle; sel picks which bus input is the awaited one
   // (0 ifu_req_ready, 1 ifu_resp_valid, 2 lsu_req_ready, 3 lsu_resp_valid),
   // every other input is random noise the controller must ignore.
   task pushCyc(input logic [9:0] o, input logic [1:0] e, input logic [6:0] op,
                input int sel, input logic val);
      cyc_t c;
      {c.irr, c.irv, c.lrr, c.lrv} = 4'($urandom);
      case (sel)
         0: c.irr = val;
         1: c.irv = val;
         2: c.lrr = val;
         3: c.lrv = val;
         default: ;
      endcase
      c.op = op;
      c.o  = o;
      c.e  = e;
      c.ir = instretM;
      trace.push_back(c);
   endtask

   // A wait phase lasts waitN+1 cycles, unless waitN reaches T, in which
   // case the T-th cycle without the handshake ends the run.
   task waitPhase(input logic [9:0] o, input int sel, input int waitN,
                  input logic [6:0] op, output bit timedOut);
      timedOut = 1'b0;
      for (int k = 1; k <= T; k++) begin
         pushCyc(o, 2'd0, op, sel, k > waitN);
         if (k > waitN) return;
         if (k == T) timedOut = 1'b1;
      end
   endtask

   task pushHalt(input logic [1:0] e, input logic [6:0] op);
      for (int k = 0; k < 4; k++) pushCyc(O_HALT, e, op, -1, 1'b0);
   endtask

   task modelInstr(input logic [6:0] op, input int fa, input int fb, input int ma,
                   input int mb, output bit h);
      bit         to;
      logic [6:0] junk;
      bit         isLoad, isStore, isBranch, isWbOnly;
      logic [9:0] wbv;
      junk     = 7'($urandom);
      h        = 1'b0;
      isLoad   = (op == 7'b0000011);
      isStore  = (op == 7'b0100011);
      isBranch = (op == 7'b1100011);
      isWbOnly = (op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111) ||
                 (op == 7'b1100111) || isBranch || (op == 7'b0010011) ||
                 (op == 7'b0110011);
      waitPhase(O_IFREQ, 0, fa, junk, to);
      if (to) begin pushHalt(2'd2, junk); h = 1'b1; return; end
      waitPhase(O_IFRSP, 1, fb, junk, to);
      if (to) begin pushHalt(2'd2, junk); h = 1'b1; return; end
      pushCyc(O_INSTWE, 2'd0, op, -1, 1'b0);
      if (op == 7'b1110011) begin pushHalt(2'd0, op); h = 1'b1; return; end
      if (!(isLoad || isStore || isWbOnly)) begin pushHalt(2'd1, op); h = 1'b1; return; end
      if (isLoad || isStore) begin
         waitPhase(O_LREQ | (isStore ? O_WEN : 10'd0), 2, ma, op, to);
         if (to) begin pushHalt(2'd2, op); h = 1'b1; return; end
         waitPhase(O_LRSP, 3, mb, op, to);
         if (to) begin pushHalt(2'd2, op); h = 1'b1; return; end
      end
      wbv = O_PCWE | ((isStore || isBranch) ? 10'd0 : O_RFWE) | (isLoad ? O_WBSEL : 10'd0);
      instretM = instretM + 32'd1;
      pushCyc(wbv, 2'd0, op, -1, 1'b0);
   endtask

   // Drives each queued cycle at the falling edge and compares all outputs
   // shortly after; reports the first cycle showing pc_we or halted.
   task applyStimulus(output int firstDone);
      cyc_t c;
      int   idx;
      firstDone = 0;
      idx       = 0;
      while (trace.size() > 0) begin
         c = trace.pop_front();
         idx++;
         @(negedge clk);
         ifu_req_ready  = c.irr;
         ifu_resp_valid = c.irv;
         lsu_req_ready  = c.lrr;
         lsu_resp_valid = c.lrv;
         opcode         = c.op;
         #1;
         checkOutput($sformatf("cycle%0d", idx), 64'({dutOut(), err, instret}),
                     64'({c.o, c.e, c.ir}));
         if (firstDone == 0 && (pc_we || halted)) firstDone = idx;
      end
   endtask

   task doReset();
      rst = 1'b0;
      #1;
      checkOutput("resetValues", 64'({dutOut(), err, instret}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("idleValues", 64'({dutOut(), err, instret}), 64'd0);
      instretM = 32'd0;
   endtask

   initial begin
      int  len;
      bit  h;
      bit  reached;
      int  sel, fa, fb, ma, mb;
      logic [6:0] pool[9];
      logic [6:0] op;

      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      opcode         = 7'd0;

      //          op          fa fb ma mb len halt err
      tbl[0]  = '{7'b0010011, 0, 0, 0, 0, 4, 1'b0, 2'd0};
      tbl[1]  = '{7'b0000011, 0, 0, 3, 0, 9, 1'b0, 2'd0};
      tbl[2]  = '{7'b0100011, 0, 0, 0, 0, 6, 1'b0, 2'd0};
      tbl[3]  = '{7'b1100011, 0, 0, 0, 0, 4, 1'b0, 2'd0};
      tbl[4]  = '{7'b1101111, 2, 1, 0, 0, 7, 1'b0, 2'd0};
      tbl[5]  = '{7'b0110111, 0, 3, 0, 0, 7, 1'b0, 2'd0};
      tbl[6]  = '{7'b0000011, 0, 0, 0, 3, 9, 1'b0, 2'd0};
      tbl[7]  = '{7'b1100111, 0, 0, 0, 0, 4, 1'b0, 2'd0};
      tbl[8]  = '{7'b1110011, 0, 0, 0, 0, 4, 1'b1, 2'd0};
      tbl[9]  = '{7'b0000000, 0, 0, 0, 0, 4, 1'b1, 2'd1};
      tbl[10] = '{7'b0110011, 0, 9, 0, 0, 6, 1'b1, 2'd2};
      tbl[11] = '{7'b0100011, 0, 0, 0, 9, 9, 1'b1, 2'd2};
      tbl[12] = '{7'b0010111, 9, 0, 0, 0, 5, 1'b1, 2'd2};
      tbl[13] = '{7'b0110001, 0, 0, 0, 0, 4, 1'b1, 2'd1};
      tbl[14] = '{7'b1111111, 1, 0, 0, 0, 5, 1'b1, 2'd1};

      #2;
      doReset();

      for (int i = 0; i < 15; i++) begin
         modelInstr(tbl[i].op, tbl[i].fa, tbl[i].fb, tbl[i].ma, tbl[i].mb, h);
         applyStimulus(len);
         checkOutput($sformatf("len%0d", i), 64'(len), 64'(tbl[i].expLen));
         checkOutput($sformatf("halt%0d", i), 64'(halted), 64'(tbl[i].expHalt));
         if (tbl[i].expHalt) begin
            checkOutput($sformatf("err%0d", i), 64'(err), 64'(tbl[i].expErr));
            doReset();
         end
      end

      pool = '{7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111,
               7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011};
      for (int n = 0; n < 80; n++) begin
         sel = $urandom_range(0, 40);
         if (sel < 37) op = pool[sel % 9];
         else if (sel < 39) op = 7'b1110011;
         else op = 7'($urandom);
         fa = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3);
         fb = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3);
         ma = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3);
         mb = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 3);
         modelInstr(op, fa, fb, ma, mb, h);
         applyStimulus(len);
         if (h) doReset();
      end

      // Reset while a load is waiting on its response.
      modelInstr(7'b0010011, 0, 0, 0, 0, h);
      applyStimulus(len);
      reached = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         ifu_req_ready  = 1'b1;
         ifu_resp_valid = 1'b1;
         lsu_req_ready  = 1'b1;
         lsu_resp_valid = 1'b0;
         opcode         = 7'b0000011;
         #1;
         if (lsu_resp_ready) begin
            reached = 1'b1;
            break;
         end
      end
      checkOutput("reachMemWait", 64'(reached), 64'd1);
      checkOutput("instretBeforeReset", 64'(instret), 64'(instretM));
      #2 rst = 1'b0;
      #1;
      checkOutput("asyncResetOutputs", 64'({dutOut(), err, instret}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      ifu_req_ready = 1'b0;
      #1;
      checkOutput("idleAfterRelease", 64'({dutOut(), err, instret}), 64'd0);
      @(negedge clk);
      #1;
      checkOutput("fetchAfterIdle", 64'({dutOut(), err, instret}),
                  64'({O_IFREQ, 2'd0, 32'd0}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
